counter_seq_ctrl: RTL
=====================

# counter_seq_ctrl

Command-driven controller that sequences a WIDTH-bit synchronous T-flip-flop counter. Accepts LOAD, STEP, RUN-for-N and STOP commands over a valid/ready handshake. Computes per-bit toggle enables for a modulo-MODULUS count and reports completion, wrap and error events as single-cycle pulses. Sits between a host/test sequencer and the counter datapath, and instantiates that datapath internally.

## Interface
- WIDTH, 3, counter width in bits
- MODULUS, 8, count wraps from MODULUS-1 to 0; legal range 2..2^WIDTH
- STEPW, 8, width of the RUN step count
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept; combinational from state only
- cmd_op  in  2  00 RUN, 01 STOP, 10 LOAD, 11 STEP
- cmd_data  in  STEPW  RUN: step count N; LOAD: value in bits [WIDTH-1:0]
- q  out  WIDTH  counter value
- busy  out  1  high while in RUNNING
- done  out  1  pulse: STEP, RUN or LOAD completed
- stopped  out  1  pulse: RUN aborted by STOP
- wrap  out  1  pulse: q advanced from MODULUS-1 to 0
- err  out  1  pulse: illegal command dropped

## Operation
- States: IDLE, RUNNING.
- Accept = cmd_valid & cmd_ready. cmd_ready = 1 in both states.
- IDLE, LOAD:
  - If cmd_data[WIDTH-1:0] < MODULUS: q takes that value; done.
  - Otherwise: q := 0; err.
- IDLE, STEP: q advances once; done.
- IDLE, RUN with N = 0: no advance; done; stay IDLE.
- IDLE, RUN with N > 0: steps_left := N; go to RUNNING.
- IDLE, STOP: no-op; no pulse.
- RUNNING: each cycle without an accepted STOP, q advances and steps_left decrements.
  - On the advance where steps_left = 1: done; go to IDLE.
- RUNNING, STOP accepted: no advance on that edge; stopped; go to IDLE; q holds.
- RUNNING, RUN/LOAD/STEP accepted: command dropped; err; counting continues on that edge.
- Advance rule:
  - If q = MODULUS-1: T = q, so all ones clear to 0; wrap.
  - Otherwise: T[0] = 1 and T[i] = &q[i-1:0], a plain binary increment.
- T is all zeros whenever no advance is scheduled.

## Timing
- Reset, asynchronous, any state including mid-RUN:
  - q = 0, state IDLE, busy = 0, steps_left = 0.
  - done, stopped, wrap and err = 0; cmd_ready = 1.
  - No done for an interrupted run.
- All pulses are registered: set on the causing edge, high for exactly one cycle.
- LOAD/STEP accepted at edge k: q updated and done high after edge k.
- RUN N > 0 accepted at edge k:
  - busy after edge k.
  - Advances at edges k+1..k+N.
  - done and busy = 0 after edge k+N.
  - Next command can be accepted at edge k+N+1.
- wrap and done may assert in the same cycle.
- err and a RUNNING advance may occur in the same cycle.
- STOP at the same edge as the final advance: STOP wins; no advance; stopped only, no done.

## Structure
- Package counter_seq_pkg holds:
  - op encodings OP_RUN, OP_STOP, OP_LOAD, OP_STEP.
  - state encodings ST_IDLE, ST_RUNNING.
- Sub-module tff_cell:
  - T flip-flop with asynchronous active-low clear.
  - Instantiated WIDTH times via generate; q is the concatenation of the cell outputs.
- LOAD writes a bit into a cell by driving T = q_i ^ load_bit.
- Control FSM, steps_left counter and pulse registers live in counter_seq_ctrl.

## Test plan
- Reset then LOAD 5 -> q = 5, done 1 cycle, err = 0.
- MODULUS = 6 variant, LOAD 5, STEP -> q = 0, wrap and done together; LOAD 7 -> q = 0, err.
- LOAD 2, RUN 4:
  - busy for 4 cycles; q = 3, 4, 5, 6.
  - done coincident with q = 6.
  - cmd_ready = 1 throughout.
- RUN 0 -> done next cycle, q unchanged, busy never high.
- LOAD 0, RUN 10, STOP issued after 3 advances -> q = 3, stopped 1 cycle, no done.
- RUN 6 from q = 6 (MODULUS = 8):
  - STEP during the run -> err pulse; run completes with q = 4 and wrap once.
  - RESET_N low mid-run -> q = 0, busy = 0, no done.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencing controller.
package counter_seq_pkg;

  // Host command opcodes as carried on cmd_op.
  typedef enum logic [1:0] {
    OP_RUN  = 2'b00,
    OP_STOP = 2'b01,
    OP_LOAD = 2'b10,
    OP_STEP = 2'b11
  } op_e;

  // Controller states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

endpackage

// File: rtl/tff_cell.sv
// One bit of the counter datapath: a T flip-flop with async active-low clear.
module tff_cell (
  input  logic CLK,
  input  logic RESET_N,
  input  logic t,
  output logic q
);

  // Toggle on t, clear on reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) q <= 1'b0;
    else if (t)   q <= ~q;
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a modulo-MODULUS T-flip-flop counter.
// The controller never writes q directly: every change, including LOAD,
// is expressed as a per-bit toggle vector into the tff_cell array.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int STEPW   = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [STEPW-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             stopped,
  output logic             wrap,
  output logic             err
);

  // Q_MAX is the last count before wrapping; MOD_W is one bit wider so a
  // full-range modulus (2^WIDTH) still compares correctly.
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  state_e           state, state_nxt;
  logic [STEPW-1:0] left, left_nxt;
  logic [WIDTH-1:0] t_vec, adv_t, ld_val;
  logic             at_max, accept, carry;
  logic             done_nxt, stopped_nxt, wrap_nxt, err_nxt;
  op_e              op;

  // Ready in every state, so a STOP can always reach a running count.
  assign cmd_ready = 1'b1;
  assign accept    = cmd_valid & cmd_ready;
  assign op        = op_e'(cmd_op);
  assign ld_val    = cmd_data[WIDTH-1:0];
  assign busy      = (state == ST_RUNNING);

  // Toggle vector for one advance: all set bits toggle at Q_MAX (clears to
  // zero), otherwise a ripple-carry binary increment.
  always_comb begin
    adv_t  = '0;
    carry  = 1'b1;
    at_max = (q == Q_MAX);
    for (int i = 0; i < WIDTH; i++) begin
      adv_t[i] = carry;
      carry    = carry & q[i];
    end
    if (at_max) adv_t = q;
  end

  // Per-bit toggle cells; q is their concatenation.
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .t       (t_vec[g]),
      .q       (q[g])
    );
  end

  // Next state, step budget, toggle vector and pulse requests.
  always_comb begin
    state_nxt   = state;
    left_nxt    = left;
    t_vec       = '0;
    done_nxt    = 1'b0;
    stopped_nxt = 1'b0;
    wrap_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_LOAD: begin
              if ({1'b0, ld_val} < MOD_W) begin
                t_vec    = q ^ ld_val;
                done_nxt = 1'b1;
              end else begin
                // Out-of-range load clears the counter.
                t_vec   = q;
                err_nxt = 1'b1;
              end
            end
            OP_STEP: begin
              t_vec    = adv_t;
              wrap_nxt = at_max;
              done_nxt = 1'b1;
            end
            OP_RUN: begin
              if (cmd_data == '0) begin
                done_nxt = 1'b1;
              end else begin
                left_nxt  = cmd_data;
                state_nxt = ST_RUNNING;
              end
            end
            default: ; // STOP while idle is a no-op
          endcase
        end
      end
      ST_RUNNING: begin
        if (accept && op == OP_STOP) begin
          // STOP beats any advance on this edge, including the last one.
          stopped_nxt = 1'b1;
          left_nxt    = '0;
          state_nxt   = ST_IDLE;
        end else begin
          t_vec    = adv_t;
          wrap_nxt = at_max;
          left_nxt = left - STEPW'(1);
          err_nxt  = accept;
          if (left == STEPW'(1)) begin
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, step budget and registered single-cycle event pulses.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      left    <= '0;
      done    <= 1'b0;
      stopped <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      left    <= left_nxt;
      done    <= done_nxt;
      stopped <= stopped_nxt;
      wrap    <= wrap_nxt;
      err     <= err_nxt;
    end
  end

endmodule
